// File: rtl/ct_idu_mat_rf_pipe8_issue_if.sv
// Dispatch, issue and commit-bus signals between the IDU pipe8 issue queue and the
// matrix ALU. The issue queue holds the "master" view; dispatch, the ALU and the
// testbench hold the "slave" view.
interface ct_idu_mat_rf_pipe8_issue_if #(
    parameter int unsigned META_W = 31
);
    // Dispatch create port
    logic              dis_mat_pipe8_create_vld;
    logic [6:0]        dis_mat_pipe8_iid;
    logic [META_W-1:0] dis_mat_pipe8_meta;
    logic              dis_mat_pipe8_src0_vld;
    logic [63:0]       dis_mat_pipe8_src0;
    logic              mat_pipe8_dis_full;
    logic              mat_pipe8_empty;

    // ALU commit bus
    logic              mat_alu_cbus_ex1_pipe8_sel;
    logic [6:0]        mat_alu_cbus_ex1_pipe8_iid;

    // RF-stage issue
    logic              idu_mat_rf_alu_sel;
    logic              idu_mat_rf_alu_gateclk_sel;
    logic [6:0]        idu_mat_rf_pipe8_iid;
    logic [META_W-1:0] idu_mat_rf_pipe8_alu_meta;
    logic              idu_mat_rf_pipe8_alu_src0_vld;
    logic [63:0]       idu_mat_rf_pipe8_alu_src0;

    modport master (
        input  dis_mat_pipe8_create_vld,
        input  dis_mat_pipe8_iid,
        input  dis_mat_pipe8_meta,
        input  dis_mat_pipe8_src0_vld,
        input  dis_mat_pipe8_src0,
        output mat_pipe8_dis_full,
        output mat_pipe8_empty,
        input  mat_alu_cbus_ex1_pipe8_sel,
        input  mat_alu_cbus_ex1_pipe8_iid,
        output idu_mat_rf_alu_sel,
        output idu_mat_rf_alu_gateclk_sel,
        output idu_mat_rf_pipe8_iid,
        output idu_mat_rf_pipe8_alu_meta,
        output idu_mat_rf_pipe8_alu_src0_vld,
        output idu_mat_rf_pipe8_alu_src0
    );

    modport slave (
        output dis_mat_pipe8_create_vld,
        output dis_mat_pipe8_iid,
        output dis_mat_pipe8_meta,
        output dis_mat_pipe8_src0_vld,
        output dis_mat_pipe8_src0,
        input  mat_pipe8_dis_full,
        input  mat_pipe8_empty,
        output mat_alu_cbus_ex1_pipe8_sel,
        output mat_alu_cbus_ex1_pipe8_iid,
        input  idu_mat_rf_alu_sel,
        input  idu_mat_rf_alu_gateclk_sel,
        input  idu_mat_rf_pipe8_iid,
        input  idu_mat_rf_pipe8_alu_meta,
        input  idu_mat_rf_pipe8_alu_src0_vld,
        input  idu_mat_rf_pipe8_alu_src0
    );
endinterface

// File: rtl/ct_idu_mat_rf_pipe8_issue.sv
// In-order issue queue for matrix-ALU pipe8. Dispatch pushes instructions; the head
// is presented to the ALU RF stage and popped when issued. Issue is throttled by the
// number of instructions issued but not yet committed on the ALU cbus.
module ct_idu_mat_rf_pipe8_issue #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned MAX_INFLIGHT = 2,
    parameter int unsigned META_W       = 31
) (
    input logic                             forever_cpuclk,
    input logic                             cpurst,
    input logic                             rtu_yy_xx_flush,
    ct_idu_mat_rf_pipe8_issue_if.master     pipe
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;
    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT) + 1;

    // Queue storage
    logic [6:0]        iid_q      [DEPTH];
    logic [META_W-1:0] meta_q     [DEPTH];
    logic              src0_vld_q [DEPTH];
    logic [63:0]       src0_q     [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;

    // Oldest-first iids of issued, uncommitted instructions; only feeds the cbus check
    logic [6:0]        shadow_q [MAX_INFLIGHT];
    logic [6:0]        shadow_d [MAX_INFLIGHT];

    logic              empty;
    logic              full;
    logic              wr_en;
    logic              can_iss;
    logic              alu_sel;
    logic              cbus_dec;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;
    logic [CNT_W-1:0]  shadow_wr_idx;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Full is registered state, so a create while full is dropped even if the head pops
    assign wr_en    = pipe.dis_mat_pipe8_create_vld && !full && !rtu_yy_xx_flush;
    assign can_iss  = !empty && (inflight_q < CNT_W'(MAX_INFLIGHT));
    assign alu_sel  = can_iss && !rtu_yy_xx_flush;
    // A commit with nothing inflight saturates at zero
    assign cbus_dec = pipe.mat_alu_cbus_ex1_pipe8_sel && !rtu_yy_xx_flush
                      && (inflight_q != '0);
    assign shadow_wr_idx = inflight_q - CNT_W'(cbus_dec);

    assign pipe.mat_pipe8_dis_full            = full;
    assign pipe.mat_pipe8_empty               = empty && (inflight_q == '0);
    assign pipe.idu_mat_rf_alu_sel            = alu_sel;
    assign pipe.idu_mat_rf_alu_gateclk_sel    = can_iss;
    assign pipe.idu_mat_rf_pipe8_iid          = iid_q[rd_idx];
    assign pipe.idu_mat_rf_pipe8_alu_meta     = meta_q[rd_idx];
    assign pipe.idu_mat_rf_pipe8_alu_src0_vld = src0_vld_q[rd_idx];
    assign pipe.idu_mat_rf_pipe8_alu_src0     = src0_q[rd_idx];

    // Next-state for pointers and the inflight counter; flush clears both
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = inflight_q;
        if (rtu_yy_xx_flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            inflight_d = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (alu_sel) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            inflight_d = inflight_q + CNT_W'(alu_sel) - CNT_W'(cbus_dec);
        end
    end

    // Shadow iid FIFO: shift out on commit, append the issued iid behind the survivors
    always_comb begin
        for (int i = 0; i < int'(MAX_INFLIGHT); i++) begin
            shadow_d[i] = shadow_q[i];
        end
        if (cbus_dec) begin
            for (int i = 0; i < int'(MAX_INFLIGHT) - 1; i++) begin
                shadow_d[i] = shadow_q[i + 1];
            end
        end
        for (int i = 0; i < int'(MAX_INFLIGHT); i++) begin
            if (alu_sel && (CNT_W'(i) == shadow_wr_idx)) begin
                shadow_d[i] = iid_q[rd_idx];
            end
        end
    end

    // Control state registers
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= '0;
            for (int i = 0; i < int'(MAX_INFLIGHT); i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            for (int i = 0; i < int'(MAX_INFLIGHT); i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    // Entry storage; cleared on reset so the issue data outputs read zero
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                iid_q[i]      <= '0;
                meta_q[i]     <= '0;
                src0_vld_q[i] <= 1'b0;
                src0_q[i]     <= '0;
            end
        end else if (wr_en) begin
            iid_q[wr_idx]      <= pipe.dis_mat_pipe8_iid;
            meta_q[wr_idx]     <= pipe.dis_mat_pipe8_meta;
            src0_vld_q[wr_idx] <= pipe.dis_mat_pipe8_src0_vld;
            src0_q[wr_idx]     <= pipe.dis_mat_pipe8_src0;
        end
    end

    // The ALU must commit in issue order and never more than it was issued
    a_cbus_order: assert property (
        @(posedge forever_cpuclk) disable iff (cpurst)
        (pipe.mat_alu_cbus_ex1_pipe8_sel && !rtu_yy_xx_flush)
            |-> ((inflight_q != '0) && (pipe.mat_alu_cbus_ex1_pipe8_iid == shadow_q[0]))
    ) else $error("pipe8 cbus commit out of order or without inflight instruction");

endmodule

// File: tb/tb_ct_idu_mat_rf_pipe8_issue.sv
// Bench for the pipe8 issue queue: a queue-level reference model predicts each cycle's
// issue, a monitor compares the DUT against those predictions, and a responder models
// the ALU committing each issued instruction one cycle later unless commits are held.
module tb_ct_idu_mat_rf_pipe8_issue;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned MAXI   = 2;
    localparam int unsigned META_W = 31;

    typedef struct packed {
        logic [6:0]        iid;
        logic [META_W-1:0] meta;
        logic              sv;
        logic [63:0]       src0;
    } entry_t;

    typedef struct {
        bit     rst;
        bit     sel;
        bit     gclk;
        bit     full;
        bit     empty;
        bit     has_head;
        entry_t head;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    ct_idu_mat_rf_pipe8_issue_if #(.META_W(META_W)) pipe ();

    ct_idu_mat_rf_pipe8_issue #(
        .DEPTH        (DEPTH),
        .MAX_INFLIGHT (MAXI),
        .META_W       (META_W)
    ) dut (
        .forever_cpuclk  (clk),
        .cpurst          (rst),
        .rtu_yy_xx_flush (flush),
        .pipe            (pipe)
    );

    always #5 clk = ~clk;

    entry_t     pending[$];
    logic [6:0] commit_q[$];
    exp_t       exp_q[$];
    int         inflight = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    bit         commit_en = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: queue of waiting instructions plus an inflight count
    always @(negedge clk) begin
        exp_t e;
        bit   full_pre;
        bit   dec;
        e.rst = 0; e.sel = 0; e.gclk = 0; e.full = 0; e.empty = 0; e.has_head = 0;
        e.head = '0;
        if (rst) begin
            pending.delete();
            commit_q.delete();
            inflight = 0;
            e.rst = 1;
            e.empty = 1;
        end else begin
            e.full     = (pending.size() == DEPTH);
            e.empty    = (pending.size() == 0) && (inflight == 0);
            e.gclk     = (pending.size() != 0) && (inflight < MAXI);
            e.sel      = e.gclk && !flush;
            e.has_head = (pending.size() != 0);
            if (e.has_head) e.head = pending[0];
            full_pre = e.full;
            dec = pipe.mat_alu_cbus_ex1_pipe8_sel && (inflight > 0);
            if (e.sel) begin
                void'(pending.pop_front());
                commit_q.push_back(e.head.iid);
            end
            if (flush) begin
                pending.delete();
                commit_q.delete();
                inflight = 0;
            end else begin
                inflight = inflight + int'(e.sel) - int'(dec);
                if (pipe.dis_mat_pipe8_create_vld && !full_pre) begin
                    pending.push_back({pipe.dis_mat_pipe8_iid, pipe.dis_mat_pipe8_meta,
                                       pipe.dis_mat_pipe8_src0_vld, pipe.dis_mat_pipe8_src0});
                end
            end
        end
        exp_q.push_back(e);
    end

    // Monitor: compares the DUT outputs of each cycle against the model's prediction
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            check("exp_queue_nonempty", 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check("alu_sel", 64'(pipe.idu_mat_rf_alu_sel), 64'(e.sel));
            check("gateclk_sel", 64'(pipe.idu_mat_rf_alu_gateclk_sel), 64'(e.gclk));
            check("dis_full", 64'(pipe.mat_pipe8_dis_full), 64'(e.full));
            check("empty", 64'(pipe.mat_pipe8_empty), 64'(e.empty));
            if (e.rst || e.has_head) begin
                check("iid", 64'(pipe.idu_mat_rf_pipe8_iid), 64'(e.head.iid));
                check("meta", 64'(pipe.idu_mat_rf_pipe8_alu_meta), 64'(e.head.meta));
                check("src0_vld", 64'(pipe.idu_mat_rf_pipe8_alu_src0_vld), 64'(e.head.sv));
                check("src0", pipe.idu_mat_rf_pipe8_alu_src0, e.head.src0);
            end
        end
    end

    // ALU responder: commits the oldest issued iid one cycle after issue unless held
    always @(posedge clk) begin
        #2;
        if (rst || !commit_en || commit_q.size() == 0) begin
            pipe.mat_alu_cbus_ex1_pipe8_sel = 1'b0;
        end else begin
            pipe.mat_alu_cbus_ex1_pipe8_sel = 1'b1;
            pipe.mat_alu_cbus_ex1_pipe8_iid = commit_q.pop_front();
        end
    end

    task automatic drive(input bit v, input logic [6:0] iid, input logic [META_W-1:0] meta,
                         input bit sv, input logic [63:0] s, input bit fl);
        pipe.dis_mat_pipe8_create_vld = v;
        pipe.dis_mat_pipe8_iid        = iid;
        pipe.dis_mat_pipe8_meta       = meta;
        pipe.dis_mat_pipe8_src0_vld   = sv;
        pipe.dis_mat_pipe8_src0       = s;
        flush                         = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit v, input logic [6:0] iid, input logic [META_W-1:0] meta,
                       input bit sv, input logic [63:0] s, input bit fl);
        drive(v, iid, meta, sv, s, fl);
        tick();
    endtask

    task automatic cyc_rand(input bit v, input bit fl);
        cyc(v, 7'($urandom_range(0, 127)), META_W'($urandom), 1'($urandom), {$urandom, $urandom},
            fl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, '0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pipe.mat_alu_cbus_ex1_pipe8_sel = 1'b0;
        pipe.mat_alu_cbus_ex1_pipe8_iid = '0;
        drive(0, '0, '0, 0, '0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single instruction
        cyc(1, 7'd5, 31'h1234567, 1, 64'hDEAD, 0);
        idle(4);

        // Back-to-back creates with prompt commits
        for (int i = 0; i < 4; i++) cyc_rand(1, 0);
        idle(6);

        // Commits withheld: two issues then stall, queue fills
        commit_en = 0;
        for (int i = 0; i < 8; i++) cyc_rand(1, 0);
        idle(3);
        commit_en = 1;
        idle(12);

        // Fill, create while full, then drain in order
        commit_en = 0;
        for (int i = 0; i < 6; i++) cyc(1, 7'(i), META_W'(i * 3 + 1), 1, 64'(i + 100), 0);
        cyc(1, 7'd9, 31'h9, 1, 64'h9, 0);
        commit_en = 1;
        idle(12);

        // Flush with work queued and inflight; create in the flush cycle is dropped
        commit_en = 0;
        for (int i = 0; i < 4; i++) cyc_rand(1, 0);
        cyc_rand(1, 1);
        commit_en = 1;
        cyc_rand(1, 0);
        idle(4);

        // Asynchronous reset while an issue is being presented
        cyc_rand(1, 0);
        drive(1, 7'd77, 31'h77, 1, 64'h77, 0);
        #2;
        rst = 1'b1;
        #1;
        check("reset_async_sel", 64'(pipe.idu_mat_rf_alu_sel), 64'd0);
        check("reset_async_empty", 64'(pipe.mat_pipe8_empty), 64'd1);
        tick();
        drive(0, '0, '0, 0, '0, 0);
        tick();
        rst = 1'b0;
        idle(5);

        // Random traffic with held commits and occasional flushes
        for (int i = 0; i < 400; i++) begin
            commit_en = ($urandom_range(0, 3) != 0);
            cyc_rand(($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
        end
        commit_en = 1;
        idle(15);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
